// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer between the execute stage and the
// data-memory bus. It accepts one request at a time, checks alignment, runs
// a single word-wide bus transaction with byte enables, and then returns
// extended load data or a fault code.
//
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   req_valid/req_ready            request handshake from the execute stage
//   mem_params, addr, wdata        decoded request, byte address, store data
//   rsp_valid/rsp_rdata/rsp_fault/rsp_cause   one-cycle response
//   busy                           request in flight (ISSUE or RESP)
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata  bus request side
//   bus_ack/bus_rdata              bus completion and read word

package mem_access_pkg;
  typedef struct packed {
    logic       op;             // 1 = read, 0 = write
    logic [1:0] access_size;    // 00 byte, 01 half, 10 word, 11 reserved
    logic       read_unsigned;
  } mem_params_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10,
    CAUSE_BAD_SIZE = 2'b11
  } cause_e;
endpackage

module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  mem_params_t       mem_params,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [1:0]        rsp_cause,
  output logic              busy,
  output logic              bus_req,
  output logic              bus_we,
  output logic [31:0]       bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_q, op_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    lane_q, lane_d;

  logic          bus_we_d;
  logic [31:0]   bus_addr_d, bus_wdata_d;
  logic [3:0]    bus_be_d;
  logic [31:0]   rsp_rdata_d;
  logic [1:0]    rsp_cause_d;

  // Picks the addressed lane out of the read word and extends it.
  function automatic logic [31:0] extract(input logic [31:0] d,
                                          input logic [1:0]  sz,
                                          input logic [1:0]  lane,
                                          input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lane, 3'b000} +: 8];
    h = d[{lane[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: extract = d;
    endcase
  endfunction

  // Ready is combinational so the stage can hand over a request the same
  // cycle the block returns to IDLE.
  assign req_ready = (state_q == IDLE) && !reset;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_be_d    = bus_be;
    bus_wdata_d = bus_wdata;
    rsp_rdata_d = 32'h0;
    rsp_cause_d = CAUSE_NONE;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d   = mem_params.op;
          size_d = mem_params.access_size;
          uns_d  = mem_params.read_unsigned;
          lane_d = addr[1:0];
          if (mem_params.access_size == 2'b11) begin
            state_d     = RESP;
            rsp_cause_d = CAUSE_BAD_SIZE;
          end else if ((mem_params.access_size == 2'b01 && addr[0]) ||
                       (mem_params.access_size == 2'b10 && addr[1:0] != 2'b00)) begin
            state_d     = RESP;
            rsp_cause_d = CAUSE_MISALIGN;
          end else begin
            // Bus fields are only loaded for requests that reach the bus,
            // and then stay frozen for the whole ISSUE phase.
            state_d    = ISSUE;
            cnt_d      = '0;
            bus_we_d   = ~mem_params.op;
            bus_addr_d = {addr[31:2], 2'b00};
            case (mem_params.access_size)
              2'b00: begin
                bus_be_d    = 4'b0001 << addr[1:0];
                bus_wdata_d = {4{wdata[7:0]}};
              end
              2'b01: begin
                bus_be_d    = 4'b0011 << {addr[1], 1'b0};
                bus_wdata_d = {2{wdata[15:0]}};
              end
              default: begin
                bus_be_d    = 4'b1111;
                bus_wdata_d = wdata;
              end
            endcase
          end
        end
      end
      ISSUE: begin
        // An ack in the last allowed cycle still completes normally.
        if (bus_ack) begin
          state_d     = RESP;
          rsp_rdata_d = op_q ? extract(bus_rdata, size_q, lane_q, uns_q) : 32'h0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = RESP;
          rsp_cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its inputs from before the edge.
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      lane_q    <= 2'b00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_cause <= 2'b00;
      rsp_rdata <= 32'h0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      lane_q    <= lane_d;
      bus_req   <= (state_d == ISSUE);
      bus_we    <= bus_we_d;
      bus_addr  <= bus_addr_d;
      bus_be    <= bus_be_d;
      bus_wdata <= bus_wdata_d;
      rsp_valid <= (state_d == RESP);
      rsp_fault <= (state_d == RESP) && (rsp_cause_d != CAUSE_NONE);
      rsp_cause <= rsp_cause_d;
      rsp_rdata <= rsp_rdata_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with TIMEOUT_CYCLES = 4.
// Inputs change just after each falling edge; outputs are checked there too.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  mem_params_t mem_params;
  logic [31:0] addr, wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [1:0]  rsp_cause;
  logic        busy;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int total  = 0;
  int passed = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_params(mem_params), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .rsp_cause(rsp_cause),
    .busy(busy),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Presents a request for one cycle; returns in the cycle after acceptance.
  task automatic drive_req(input logic op, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd);
    total++;
    if (req_ready !== 1'b1) $display("FAIL req_ready_before_accept act=%b exp=1", req_ready);
    else passed++;
    req_valid  = 1'b1;
    mem_params = '{op: op, access_size: sz, read_unsigned: uns};
    addr       = a;
    wdata      = wd;
    @(negedge clk);
    req_valid  = 1'b0;
    mem_params = '0;
    addr       = 32'h0;
    wdata      = 32'h0;
  endtask

  // Pulses bus_ack for the current cycle and moves on one cycle.
  task automatic ack_now(input logic [31:0] rd);
    bus_ack   = 1'b1;
    bus_rdata = rd;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0) $display("FAIL reset_req_ready act=%b exp=0", req_ready); else passed++;
    total++;
    if ({rsp_valid, rsp_fault, rsp_cause, busy, bus_req, bus_we} !== 7'b0)
      $display("FAIL reset_ctrl act=%b exp=0", {rsp_valid, rsp_fault, rsp_cause, busy, bus_req, bus_we});
    else passed++;
    total++;
    if ({rsp_rdata, bus_addr, bus_be, bus_wdata} !== 100'h0)
      $display("FAIL reset_data act=%h exp=0", {rsp_rdata, bus_addr, bus_be, bus_wdata});
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) $display("FAIL post_reset_ready act=%b exp=1", req_ready); else passed++;
  endtask

  task automatic test_word_store();
    drive_req(1'b0, 2'b10, 1'b0, 32'h1000_0008, 32'hDEAD_BEEF);
    total++;
    if ({bus_req, bus_we, bus_be, busy} !== 7'b1_1_1111_1)
      $display("FAIL wst_ctrl act=%b exp=1111111", {bus_req, bus_we, bus_be, busy});
    else passed++;
    total++;
    if (bus_addr !== 32'h1000_0008 || bus_wdata !== 32'hDEAD_BEEF)
      $display("FAIL wst_bus act=%h/%h exp=10000008/deadbeef", bus_addr, bus_wdata);
    else passed++;
    ack_now(32'hFFFF_FFFF);
    total++;
    if ({rsp_valid, rsp_fault, rsp_cause, bus_req} !== 5'b1_0_00_0 || rsp_rdata !== 32'h0)
      $display("FAIL wst_rsp act=%b/%h exp=10000/0", {rsp_valid, rsp_fault, rsp_cause, bus_req}, rsp_rdata);
    else passed++;
    @(negedge clk);
    total++;
    if ({rsp_valid, busy, req_ready} !== 3'b001)
      $display("FAIL wst_idle act=%b exp=001", {rsp_valid, busy, req_ready});
    else passed++;
  endtask

  task automatic test_byte_load(input logic uns, input logic [31:0] exp);
    drive_req(1'b1, 2'b00, uns, 32'h2000_0003, 32'h0);
    total++;
    if ({bus_req, bus_we, bus_be} !== 6'b1_0_1000 || bus_addr !== 32'h2000_0000)
      $display("FAIL bld_bus uns=%b act=%b/%h exp=101000/20000000", uns, {bus_req, bus_we, bus_be}, bus_addr);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus_req, rsp_valid} !== 2'b10)
      $display("FAIL bld_wait uns=%b act=%b exp=10", uns, {bus_req, rsp_valid});
    else passed++;
    ack_now(32'h80FF_1234);
    total++;
    if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_rdata !== exp)
      $display("FAIL bld_rsp uns=%b act=%b%b/%h exp=10/%h", uns, rsp_valid, rsp_fault, rsp_rdata, exp);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_half();
    drive_req(1'b0, 2'b01, 1'b0, 32'h3000_0002, 32'h0000_ABCD);
    total++;
    if (bus_be !== 4'b1100 || bus_wdata !== 32'hABCD_ABCD || bus_we !== 1'b1)
      $display("FAIL hst_bus act=%b/%h/%b exp=1100/abcdabcd/1", bus_be, bus_wdata, bus_we);
    else passed++;
    ack_now(32'h0);
    @(negedge clk);
    drive_req(1'b1, 2'b01, 1'b0, 32'h3000_0002, 32'h0);
    ack_now(32'h7FFF_0000);
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_7FFF)
      $display("FAIL hld_hi act=%b/%h exp=1/00007fff", rsp_valid, rsp_rdata);
    else passed++;
    @(negedge clk);
    drive_req(1'b1, 2'b01, 1'b0, 32'h3000_0000, 32'h0);
    total++;
    if (bus_be !== 4'b0011) $display("FAIL hld_lo_be act=%b exp=0011", bus_be); else passed++;
    ack_now(32'h1234_8001);
    total++;
    if (rsp_rdata !== 32'hFFFF_8001) $display("FAIL hld_lo_signed act=%h exp=ffff8001", rsp_rdata);
    else passed++;
    @(negedge clk);
    // Word load ignores read_unsigned.
    drive_req(1'b1, 2'b10, 1'b1, 32'h3000_0004, 32'h0);
    ack_now(32'h8765_4321);
    total++;
    if (rsp_rdata !== 32'h8765_4321) $display("FAIL wld act=%h exp=87654321", rsp_rdata); else passed++;
    @(negedge clk);
  endtask

  task automatic test_faults();
    logic [1:0]  sz  [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] ad  [3] = '{32'h5000_0001, 32'h5000_0002, 32'h5000_0000};
    logic [1:0]  cz  [3] = '{2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b1, sz[i], 1'b0, ad[i], 32'h0);
      total++;
      if ({rsp_valid, rsp_fault, rsp_cause, bus_req} !== {2'b11, cz[i], 1'b0} || rsp_rdata !== 32'h0)
        $display("FAIL fault%0d act=%b/%h exp=%b/0", i, {rsp_valid, rsp_fault, rsp_cause, bus_req},
                 rsp_rdata, {2'b11, cz[i], 1'b0});
      else passed++;
      @(negedge clk);
      total++;
      if ({rsp_valid, bus_req, req_ready} !== 3'b001)
        $display("FAIL fault%0d_after act=%b exp=001", i, {rsp_valid, bus_req, req_ready});
      else passed++;
    end
  endtask

  task automatic test_timeout();
    int hi;
    bit got;
    hi  = 0;
    got = 1'b0;
    drive_req(1'b1, 2'b10, 1'b0, 32'h6000_0000, 32'h0);
    for (int i = 0; i < 12 && !got; i++) begin
      if (bus_req) hi++;
      if (rsp_valid) got = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!got || hi != 4 || rsp_cause !== 2'b10 || rsp_fault !== 1'b1)
      $display("FAIL timeout act=got%0d/hi%0d/%b%b exp=got1/hi4/110", got, hi, rsp_fault, rsp_cause);
    else passed++;
    @(negedge clk);
    // Ack in the fourth and last allowed cycle wins.
    drive_req(1'b1, 2'b10, 1'b0, 32'h6000_0004, 32'h0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    ack_now(32'hCAFE_F00D);
    total++;
    if ({rsp_valid, rsp_fault, rsp_cause} !== 4'b1000 || rsp_rdata !== 32'hCAFE_F00D)
      $display("FAIL last_ack act=%b/%h exp=1000/cafef00d", {rsp_valid, rsp_fault, rsp_cause}, rsp_rdata);
    else passed++;
    @(negedge clk);
    // Stray ack while idle.
    bus_ack   = 1'b1;
    bus_rdata = 32'h1111_2222;
    @(negedge clk);
    @(negedge clk);
    bus_ack   = 1'b0;
    total++;
    if ({rsp_valid, busy, bus_req, req_ready} !== 4'b0001)
      $display("FAIL stray_ack act=%b exp=0001", {rsp_valid, busy, bus_req, req_ready});
    else passed++;
  endtask

  task automatic test_reset_mid();
    drive_req(1'b1, 2'b10, 1'b0, 32'h7000_0000, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({bus_req, busy, rsp_valid, req_ready} !== 4'b0000)
      $display("FAIL mid_reset act=%b exp=0000", {bus_req, busy, rsp_valid, req_ready});
    else passed++;
    reset = 1'b0;
    ack_now(32'h9999_9999);
    total++;
    if ({rsp_valid, busy, req_ready} !== 3'b001)
      $display("FAIL late_ack act=%b exp=001", {rsp_valid, busy, req_ready});
    else passed++;
    drive_req(1'b0, 2'b00, 1'b0, 32'h4000_0001, 32'h0000_00A5);
    total++;
    if (bus_be !== 4'b0010 || bus_wdata !== 32'hA5A5_A5A5 || bus_req !== 1'b1)
      $display("FAIL post_reset_bus act=%b/%h/%b exp=0010/a5a5a5a5/1", bus_be, bus_wdata, bus_req);
    else passed++;
    ack_now(32'h0);
    total++;
    if ({rsp_valid, rsp_fault} !== 2'b10) $display("FAIL post_reset_rsp act=%b exp=10", {rsp_valid, rsp_fault});
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    mem_params = '0;
    addr       = 32'h0;
    wdata      = 32'h0;
    bus_ack    = 1'b0;
    bus_rdata  = 32'h0;
    test_reset();
    test_word_store();
    test_byte_load(1'b0, 32'hFFFF_FF80);
    test_byte_load(1'b1, 32'h0000_0080);
    test_half();
    test_faults();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store sequencer between the execute stage and the data-memory bus. Accepts one decoded memory request (`mem_params_t` plus address and store data), checks alignment, drives a single-outstanding word-wide bus transaction with byte enables, and returns sign/zero-extended load data or a fault. The pipeline stalls on `busy` while a request is in flight.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum number of cycles `bus_req` is held waiting for `bus_ack` before a timeout fault. Must be ≥ 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  execute stage presents a memory request.
- `req_ready`  out  1  block can accept a request this cycle.
- `mem_params`  in  mem_params_t  fields:
  - `op`: 1 = read, 0 = write.
  - `access_size`: 00 byte, 01 half, 10 word, 11 reserved.
  - `read_unsigned`
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  32  extended load data; 0 for stores and faults.
- `rsp_fault`  out  1  request faulted; qualified by `rsp_valid`.
- `rsp_cause`  out  2  cause code: 00 none, 01 misaligned, 10 timeout, 11 bad size.
- `busy`  out  1  request accepted and not yet responded.
- `bus_req`  out  1  bus transaction request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word-aligned address (`addr[31:2]`, 2'b00).
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_ack`  in  1  transaction complete; `bus_rdata` valid this cycle for reads.
- `bus_rdata`  in  32  read word.

## Operation
- **States:** IDLE, ISSUE, RESP.
- **IDLE:** `req_ready`=1 (forced 0 while `reset`). On `req_valid & req_ready`, latch `op`, `access_size`, `read_unsigned`, `addr`, `wdata`, then classify:
  - size 11 → RESP with cause 11.
  - half with `addr[0]`=1, or word with `addr[1:0]`≠0 → RESP with cause 01.
  - otherwise → ISSUE, with the timeout counter cleared to 0.
  - Faulted requests never assert `bus_req`.
- **ISSUE:** `bus_req`=1. `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` are stable for the whole state.
  - `bus_ack`=1 → capture read data, go to RESP with cause 00.
  - Otherwise, if the counter equals `TIMEOUT_CYCLES`-1 → RESP with cause 10.
  - Otherwise → increment the counter.
  - An ack on the final allowed cycle wins over the timeout.
- **RESP:** `rsp_valid`=1 for exactly one cycle, then IDLE. `rsp_fault`=(cause≠00).
- **Byte enables:**
  - byte: `bus_be` = 4'b0001 << `addr[1:0]`; `bus_wdata` = {4{`wdata[7:0]`}}.
  - half: `bus_be` = 4'b0011 << {`addr[1]`,1'b0}; `bus_wdata` = {2{`wdata[15:0]`}}.
  - word: `bus_be` = 4'b1111; `bus_wdata` = `wdata`.
  - Reads drive the same `bus_be` pattern.
- **Load extraction:**
  - byte: `bus_rdata[8*addr[1:0] +: 8]`.
  - half: `bus_rdata[16*addr[1] +: 16]`.
  - The result is zero-extended when `read_unsigned`, else sign-extended.
  - Word loads ignore `read_unsigned`.
- **Stores:** `rsp_rdata`=0. `bus_rdata` is ignored.
- **Stray acks:** `bus_ack` outside ISSUE is ignored.
- **`busy`:** =1 in ISSUE and RESP.

## Timing
- **Reset values:** state IDLE, counter 0. `req_ready` 0 during reset, then 1. `rsp_valid`, `rsp_fault`, `rsp_cause`, `rsp_rdata`, `busy`, `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata` all 0.
- **Registered outputs:** all outputs except `req_ready` are registered (Moore).
- **Latency:**
  - Accept at edge N → `bus_req` high in cycle N+1.
  - Ack seen in cycle N+k (k ≥ 1; k=1 means ack in the same cycle `bus_req` first rises) → `rsp_valid` in cycle N+k+1.
  - Fault-at-accept → `rsp_valid` in cycle N+1.
  - Timeout → `bus_req` high exactly `TIMEOUT_CYCLES` cycles; `rsp_valid` the cycle after the last one.
- **Throughput:** back-to-back requests are accepted in the cycle after RESP. The minimum spacing is 3 cycles for a bus request and 2 for a fault.
- **Reset mid-operation:** reset asserted in any state → state IDLE and all outputs at reset values at the next edge. No response is produced for the aborted request. A late `bus_ack` is ignored.

## Test plan
- **Word store, immediate ack:** `addr`=0x1000_0008, `op`=0, size 10, `wdata`=0xDEADBEEF, `bus_ack` first ISSUE cycle → `bus_we`=1, `bus_be`=1111, `bus_addr`=0x1000_0008; `rsp_valid` 2 cycles after accept, `rsp_fault`=0, `rsp_rdata`=0.
- **Byte loads, signed/unsigned:** `addr`=0x...03, size 00, `bus_rdata`=0x80FF_1234, ack after 3 cycles → `bus_be`=1000. `read_unsigned`=0 gives `rsp_rdata`=0xFFFF_FF80; `read_unsigned`=1 gives 0x0000_0080.
- **Half store, upper lane:** `addr`=0x...02, `wdata`=0x0000_ABCD → `bus_be`=1100, `bus_wdata`=0xABCD_ABCD. Half load at 0x...02 with `bus_rdata`=0x7FFF_0000, signed → 0x0000_7FFF.
- **Faults at accept:** half at 0x...01 → cause 01; word at 0x...02 → cause 01; size 11 → cause 11. All produce `rsp_valid` at N+1 with `bus_req` never asserted.
- **Timeout boundary (`TIMEOUT_CYCLES`=4):**
  - No ack → `bus_req` high 4 cycles, then cause 10.
  - Ack on the 4th cycle → cause 00 with data.
  - A stray ack in IDLE has no effect.
- **Reset mid-ISSUE:** reset after 2 ISSUE cycles → next cycle `bus_req`=0, `busy`=0, no `rsp_valid`. A new request after reset deasserts completes normally.
